// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encoding and
// default memory geometry.
package fetch_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StHalted = 3'd2,
    StFault  = 3'd3
  } fetch_state_e;

  localparam logic [31:0] ResetPcDefault   = 32'h0000_0000;
  localparam int unsigned ImemDepthDefault = 1024;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: fetch PC register, accepted-fetch counter and
// IDLE/FETCH/HALTED/FAULT sequencer driving the instruction memory and IF/ID register.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = ResetPcDefault,
  parameter int unsigned IMEM_DEPTH = ImemDepthDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        stall_hz,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        imem_ready,
  output logic [31:0] pc_f,
  output logic        imem_req,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        fault,
  output logic [2:0]  state_o,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] DepthW = 32'(IMEM_DEPTH);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  r_count;
  logic         r_fault;
  logic         w_oob;

  // Out-of-range PC outranks every other FETCH input.
  assign w_oob = (r_pc >= DepthW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (start) w_state_next = StFetch;
      StFetch: begin
        if (w_oob) begin
          w_state_next = StFault;
        end else if (!branch_taken && !stall_hz && halt_req) begin
          w_state_next = StHalted;
        end
      end
      StHalted: if (start) w_state_next = StFetch;
      StFault:  w_state_next = StFault;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    ifid_we    = 1'b0;
    ifid_flush = 1'b0;
    if (r_state == StFetch) begin
      imem_req = !w_oob;
      if (w_oob || branch_taken) begin
        ifid_flush = 1'b1;
      end else if (!stall_hz) begin
        if (!halt_req && imem_ready) begin
          ifid_we = 1'b1;
        end else begin
          ifid_flush = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_pc_next = r_pc;
    if (r_state == StFetch && !w_oob) begin
      if (branch_taken) begin
        w_pc_next = branch_target;
      end else if (ifid_we) begin
        w_pc_next = r_pc + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_count <= 32'd0;
      r_fault <= 1'b0;
    end else begin
      r_pc <= w_pc_next;
      if (ifid_we) begin
        r_count <= r_count + 32'd1;
      end
      if (r_state == StFetch && w_oob) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign pc_f        = r_pc;
  assign fault       = r_fault;
  assign state_o     = r_state;
  assign fetch_count = r_count;

endmodule
